// File: rtl/muldiv_sequencer_if.sv
// Purpose: core <-> M-extension sequencer handshake (start/operands in, busy/done/result/stall out).
// Latency: none, wires only.
// Backpressure: the core holds start and freezes on stall until done pulses.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    // Core side: issues the M-type op and watches for completion.
    modport master (
        output start, funct3, op_a, op_b,
        input  busy, done, result, stall
    );

    // Sequencer side.
    modport slave (
        input  start, funct3, op_a, op_b,
        output busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Purpose: RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on one shared shift/add-sub datapath.
// Latency: 34 cycles iterative, 1 cycle for div-by-zero/overflow (and multiplies with FAST_MUL_EN).
// Backpressure: stall holds the core while busy; start is ignored outside IDLE.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    muldiv_sequencer_if.slave    bus
);
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        f3_q;
    logic              sign_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // Operand decode at acceptance
    logic            a_signed, b_signed, a_neg, b_neg, sign_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast_hit, early_hit;
    logic [XLEN-1:0] short_res, fast_res, early_res;

    // Shared iteration datapath and final fix-up
    logic [XLEN:0]     alu_a, alu_b;
    logic [XLEN+1:0]   alu_b_x, alu_sum;
    logic              q_bit;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Decode signedness, magnitudes, result sign and the single-cycle shortcuts from the live inputs.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            F_MULH, F_DIV, F_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F_MULHSU: a_signed = 1'b1;
            default:  ;
        endcase
        a_neg   = a_signed & bus.op_a[XLEN-1];
        b_neg   = b_signed & bus.op_b[XLEN-1];
        // REM follows the dividend; MULHSU gets b_neg = 0 so the xor reduces to sign(a).
        sign_in = (bus.funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
        a_mag   = a_neg ? -bus.op_a : bus.op_a;
        b_mag   = b_neg ? -bus.op_b : bus.op_b;

        div_zero  = bus.funct3[2] & (bus.op_b == '0);
        div_ovf   = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                    (bus.op_a == INT_MIN) && (bus.op_b == '1);
        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero)
            short_res = bus.funct3[1] ? bus.op_a : '1;
        else
            short_res = bus.funct3[1] ? '0 : INT_MIN;
    end

`ifdef FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;

    // Single-cycle 33x33 product: the extra top bit carries the operand sign only for signed operands.
    always_comb begin
        fast_a    = {a_neg, bus.op_a};
        fast_b    = {b_neg, bus.op_b};
        fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
        fast_hit  = ~bus.funct3[2];
        fast_res  = (bus.funct3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    // Multiplies always take the iterative path in this build.
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
    end
`endif

    // Ops that finish on the accepting edge and their result.
    always_comb begin
        early_hit = div_zero | div_ovf | fast_hit;
        early_res = (div_zero | div_ovf) ? short_res : fast_res;
    end

    // One iteration: shift-add for multiply, shift-subtract-restore for divide, sharing one adder.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_b_x  = '0;
        alu_sum  = '0;
        q_bit    = 1'b0;
        acc_step = acc_q;
        if (f3_q[2]) begin
            alu_a    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
            alu_b    = {1'b0, opnd_q};
            alu_b_x  = ~{1'b0, alu_b};
            alu_sum  = {1'b0, alu_a} + alu_b_x + {{(XLEN+1){1'b0}}, 1'b1};
            // No borrow out of the top bit means the shifted remainder covered the divisor.
            q_bit    = ~alu_sum[XLEN+1];
            acc_step = {(q_bit ? alu_sum[XLEN-1:0] : alu_a[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
        end else begin
            alu_a    = {1'b0, acc_q[2*XLEN-1:XLEN]};
            alu_b    = acc_q[0] ? {1'b0, opnd_q} : '0;
            alu_b_x  = {1'b0, alu_b};
            alu_sum  = {1'b0, alu_a} + alu_b_x;
            acc_step = {alu_sum[XLEN:0], acc_q[XLEN-1:1]};
        end
    end

    // Apply the recorded sign and pick the half/part the op asks for.
    always_comb begin
        prod_fix = sign_q ? -acc_q : acc_q;
        quo_fix  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            F_MUL:                    fix_res = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:            fix_res = quo_fix;
            F_REM, F_REMU:            fix_res = rem_fix;
            default:                  fix_res = '0;
        endcase
    end

    // State register; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept in IDLE, 32 iterations in CALC, one fix-up cycle, one done cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = early_hit ? DONE : CALC;
            CALC: if (cnt_q == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: latch op on acceptance, iterate in CALC, register the result in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q     <= '0;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    f3_q   <= bus.funct3;
                    sign_q <= sign_in;
                    cnt_q  <= '0;
                    if (bus.funct3[2]) begin
                        opnd_q <= b_mag;
                        acc_q  <= {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opnd_q <= a_mag;
                        acc_q  <= {{XLEN{1'b0}}, b_mag};
                    end
                    if (early_hit) result_q <= early_res;
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX:     result_q <= fix_res;
                default: ;
            endcase
        end
    end

    // Status outputs; stall drops in DONE so the core retires on that edge.
    always_comb begin
        bus.busy   = (state == CALC) || (state == FIX);
        bus.done   = (state == DONE);
        bus.result = result_q;
        bus.stall  = ((state == IDLE) && bus.start) || (state == CALC) || (state == FIX);
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Purpose: directed + random checks of muldiv_sequencer with a result scoreboard.
// Latency: expects 34 cycles iterative, 1 for shortcuts (and multiplies when FAST_MUL_EN is set).
// Backpressure: start is held through each op as the core would.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM  = 3'd6, F_REMU  = 3'd7;

    logic clk = 1'b0;
    logic rst_n;

    muldiv_sequencer_if #(.XLEN(XLEN)) mif();

    muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            F_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            F_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            F_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            F_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
            F_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            F_REM:    begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
            default:  begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((f3 == F_DIV || f3 == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    // Issue one op at a negedge in IDLE (or in DONE when chaining), wait for done, score it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit hold, input bit from_done);
        int n, bad;
        bit got;
        mif.funct3 = f3;
        mif.op_a   = a;
        mif.op_b   = b;
        mif.start  = 1'b1;
        exp_q.push_back(exp);
        #1;
        if (from_done) begin
            @(negedge clk);
            check("single_done_pulse", {31'b0, mif.done}, 32'd0);
        end
        check("stall_cycle0", {31'b0, mif.stall}, 32'd1);
        check("busy_cycle0", {31'b0, mif.busy}, 32'd0);
        n   = 0;
        bad = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (mif.done) got = 1'b1;
            else begin
                if (mif.stall !== 1'b1 || mif.busy !== 1'b1) bad++;
                if (n == 1) begin
                    mif.funct3 = 3'($urandom);
                    mif.op_a   = $urandom;
                    mif.op_b   = $urandom;
                end
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        check("stall_busy_while_running", bad, 0);
        if (got) begin
            check("latency", n, lat);
            check("stall_in_done", {31'b0, mif.stall}, 32'd0);
            check("result", mif.result, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx);
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        if (!hold) begin
            mif.start = 1'b0;
            @(negedge clk);
            check("done_dropped", {31'b0, mif.done}, 32'd0);
        end
    endtask

    initial begin
        int n_done;
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst_n      = 1'b0;
        mif.start  = 1'b0;
        mif.funct3 = '0;
        mif.op_a   = '0;
        mif.op_b   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, mif.busy}, 32'd0);
        check("rst_done", {31'b0, mif.done}, 32'd0);
        check("rst_stall", {31'b0, mif.stall}, 32'd0);
        check("rst_result", mif.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 0, 0);
        run_op(F_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 0, 0);
        run_op(F_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT, 0, 0);
        run_op(F_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DIV_LAT, 0, 0);
        run_op(F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
        run_op(F_REMU, 32'd5, 32'd0, 32'd5, 1, 0, 0);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
        run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
        run_op(F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0, 0);
        run_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0, 0);
        run_op(F_MUL, 32'd12345, 32'd6789, 32'd83810205, MUL_LAT, 0, 0);
        run_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0, 0);

        // Reset in the middle of a DIVU: everything clears at once, no late done.
        mif.funct3 = F_DIVU;
        mif.op_a   = 32'd1000;
        mif.op_b   = 32'd7;
        mif.start  = 1'b1;
        repeat (10) @(negedge clk);
        rst_n     = 1'b0;
        mif.start = 1'b0;
        #1;
        check("midrst_busy", {31'b0, mif.busy}, 32'd0);
        check("midrst_stall", {31'b0, mif.stall}, 32'd0);
        check("midrst_done", {31'b0, mif.done}, 32'd0);
        check("midrst_result", mif.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done) n_done++;
        end
        check("no_done_after_rst", n_done, 0);
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT, 0, 0);

        // Back-to-back with start held continuously across DONE.
        run_op(F_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, 1, 0);
        run_op(F_DIVU, 32'd9, 32'd2, 32'd4, DIV_LAT, 0, 1);

        // Random ops scored against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) b = 32'd0;
            if (i % 4 == 2) b = 32'($urandom_range(1, 300));
            run_op(f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32 M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU. The decoder raises start for opcode 0110011 with funct7 = 0000001.
- Drives stall to freeze PC/regfile writeback until the result is ready.
- Owns one shared shift/add-subtract datapath and sequences it through an FSM.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  M-type instruction present; held high by the core until done
- funct3  in  3  M-op select, per RISC-V encoding
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result, held until the next op completes
- stall  out  1  core stall request

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, busy = 0, done = 0, result = 0, counter = 0, internal accumulators = 0. Reset mid-operation aborts immediately to IDLE with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On a clk edge with start = 1, latch funct3 and operand magnitudes.
  - Record result sign:
    - MULH: sign(a) ^ sign(b).
    - MULHSU: sign(a).
    - DIV: sign(a) ^ sign(b).
    - REM: sign(a).
    - Unsigned ops: 0.
  - Load counter = 0 and go to CALC.
  - Special-case shortcuts go straight to DONE with result written on the same edge:
    - Divide-by-zero (op_b = 0, funct3 1xx): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
    - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle; the counter increments and the state moves to FIX on the edge where counter = 31, i.e. after exactly 32 iterations.
  - MUL*: shift-add into a 64-bit accumulator on magnitudes.
  - DIV*/REM*: restoring division with a 33-bit partial remainder, producing one quotient bit per cycle.
- FIX: one cycle.
  - Two's-complement negate the 64-bit product, quotient or remainder when the recorded sign = 1.
  - Select the output: MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register the selection into result and go to DONE.
- DONE: done = 1 for exactly one cycle, then unconditionally return to IDLE. start is ignored in DONE, since the core still holds it for the retiring instruction.
- Latency: done is high during cycle 34 after the start-accepting edge (1 IDLE→CALC edge + 32 CALC + 1 FIX). Shortcut paths have 1-cycle latency.
- stall = (state == IDLE & start) | (state == CALC) | (state == FIX). stall is combinational, and 0 in DONE so the core advances on that edge.
- start is ignored while busy. funct3/op_a/op_b changes after acceptance have no effect.
- Back-to-back: start high in IDLE on the cycle after DONE begins a new operation.

Optional Feature:
- Macro FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute a combinational 64-bit signed-extended product (33x33) in IDLE.
  - Result is written on the accepting edge, IDLE→DONE; done is high in the next cycle (latency 1).
  - Divide path is unchanged.
- Undefined: all multiplies use the 34-cycle iterative path above; no hardware multiplier is inferred.

Test Plan:
- DIVU op_a = 100, op_b = 7 -> done in cycle 34, result = 14; REMU same operands -> result = 2; stall high cycles 0–33.
- DIV op_a = -20 (0xFFFFFFEC), op_b = 3 -> result = 0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2).
- DIV op_b = 0, op_a = 5 -> done next cycle, result = 0xFFFFFFFF; REMU op_b = 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MUL 12345 × 6789 -> 83810205. Latency is 34 without FAST_MUL_EN and 1 with it.
- Assert rst_n low at cycle 10 of a DIVU -> busy/stall/done/result immediately 0 and state IDLE. The next DIVU 9/3 after release -> 3.
- Back-to-back MUL 3×4 then DIVU 9/2 with start held continuously -> two single done pulses, results 12 then 4, start ignored during DONE.
